ib32bit_fetch: RTL and testbench

Instruction fetch stage of the 32-bit processor: it computes the next program counter for the PC register and consumes the PC register's output.
- It issues reads to the synchronous instruction memory.
- It delivers instructions, tagged with their PC, to decode over a valid/ready handshake.
- It absorbs decode back-pressure with a one-entry skid buffer.
- It squashes wrong-path fetches on branch and jump redirects.

---
 rtl/ib32bit_pkg.sv | 13 +
 rtl/ib32bit_fetch_buf.sv | 75 +++++++
 rtl/ib32bit_fetch.sv | 96 +++++++++
 tb/tb_ib32bit_fetch.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ib32bit_pkg.sv
// Shared definitions for the ib32bit instruction fetch stage: default widths
// and the {instruction, PC} entry carried through the fetch buffer.
package ib32bit_pkg;

    localparam int IB_AWIDTH = 6;
    localparam int IB_DWIDTH = 32;

    typedef struct packed {
        logic [IB_DWIDTH-1:0] data;
        logic [IB_AWIDTH-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/ib32bit_fetch_buf.sv
// Two-entry holding buffer in front of decode: the IR register plus a one-entry
// skid that absorbs the single read still returning when decode stalls.
module ib32bit_fetch_buf
    import ib32bit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  fetch_entry_t push_entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic         ir_valid_o,
    output fetch_entry_t ir_entry_o,
    output logic         full_o,
    output logic [1:0]   occupancy_o
);

    logic         ir_valid_q,   ir_valid_d;
    fetch_entry_t ir_entry_q,   ir_entry_d;
    logic         skid_valid_q, skid_valid_d;
    fetch_entry_t skid_entry_q, skid_entry_d;

    always_comb begin
        ir_valid_d   = ir_valid_q;
        ir_entry_d   = ir_entry_q;
        skid_valid_d = skid_valid_q;
        skid_entry_d = skid_entry_q;
        if (flush_i) begin
            ir_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
        end else if (pop_i && skid_valid_q) begin
            // Skid entry is older than anything returning, so it moves up first.
            ir_valid_d   = 1'b1;
            ir_entry_d   = skid_entry_q;
            skid_valid_d = push_i;
            if (push_i) begin
                skid_entry_d = push_entry_i;
            end
        end else if (pop_i || !ir_valid_q) begin
            ir_valid_d = push_i;
            if (push_i) begin
                ir_entry_d = push_entry_i;
            end
        end else if (push_i) begin
            skid_valid_d = 1'b1;
            skid_entry_d = push_entry_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_valid_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            ir_entry_q   <= '0;
        end else begin
            ir_valid_q   <= ir_valid_d;
            skid_valid_q <= skid_valid_d;
            ir_entry_q   <= ir_entry_d;
        end
    end

    // Skid payload is only meaningful while skid_valid_q is set.
    always_ff @(posedge clk) begin
        skid_entry_q <= skid_entry_d;
    end

    assign ir_valid_o  = ir_valid_q;
    assign ir_entry_o  = ir_entry_q;
    assign full_o      = ir_valid_q & skid_valid_q;
    assign occupancy_o = {1'b0, ir_valid_q} + {1'b0, skid_valid_q};

    assert property (@(posedge clk) disable iff (rst)
        !(push_i && !pop_i && !flush_i && ir_valid_q && skid_valid_q));

endmodule

// File: rtl/ib32bit_fetch.sv
// Instruction fetch: next-PC selection, memory read issue, in-flight tracking
// and squash on redirect; fetched words are held for decode in ib32bit_fetch_buf.
module ib32bit_fetch
    import ib32bit_pkg::*;
#(
    parameter int AWIDTH = IB_AWIDTH,
    parameter int DWIDTH = IB_DWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] pc,
    output logic [AWIDTH-1:0] next_pc,
    output logic [AWIDTH-1:0] imem_addr,
    input  logic [DWIDTH-1:0] imem_rdata,
    input  logic              br_taken,
    input  logic [AWIDTH-1:0] br_target,
    input  logic              jmp,
    input  logic [AWIDTH-1:0] jmp_target,
    output logic              ir_valid,
    output logic [DWIDTH-1:0] ir_data,
    output logic [AWIDTH-1:0] ir_pc,
    input  logic              ir_ready
);

    logic              inflight_q,    inflight_d;
    logic [AWIDTH-1:0] inflight_pc_q, inflight_pc_d;

    logic         redirect;
    logic         deq;
    logic         issue;
    logic         push;
    logic [1:0]   count;
    logic [1:0]   in_use;
    logic [1:0]   buf_occupancy;
    logic         buf_full;
    fetch_entry_t push_entry;
    fetch_entry_t ir_entry;

    assign redirect  = br_taken | jmp;
    assign deq       = ir_valid & ir_ready;
    assign count     = buf_occupancy + {1'b0, inflight_q};
    // A dequeue this cycle frees a slot in time for the word issued now.
    assign in_use    = count - {1'b0, deq};
    assign issue     = !rst && !redirect && (in_use < 2'd2);
    assign push      = inflight_q & !redirect;
    assign imem_addr = pc;

    always_comb begin
        next_pc = pc;
        if (rst) begin
            next_pc = '0;
        end else if (br_taken) begin
            next_pc = br_target;
        end else if (jmp) begin
            next_pc = jmp_target;
        end else if (issue) begin
            next_pc = pc + AWIDTH'(1);
        end
    end

    assign inflight_d    = issue;
    assign inflight_pc_d = issue ? pc : inflight_pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        inflight_pc_q <= inflight_pc_d;
    end

    assign push_entry = '{data: imem_rdata, pc: inflight_pc_q};

    ib32bit_fetch_buf u_buf (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (deq),
        .flush_i      (redirect),
        .ir_valid_o   (ir_valid),
        .ir_entry_o   (ir_entry),
        .full_o       (buf_full),
        .occupancy_o  (buf_occupancy)
    );

    assign ir_data = ir_entry.data;
    assign ir_pc   = ir_entry.pc;

    assert property (@(posedge clk) disable iff (rst) !(buf_full && inflight_q));

endmodule

// File: tb/tb_ib32bit_fetch.sv
// Directed bench for ib32bit_fetch with a behavioural PC register and a
// synchronous instruction memory returning 0xA000_0000 + address.
module tb_ib32bit_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  pc = '0;
    logic [5:0]  next_pc;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        br_taken;
    logic [5:0]  br_target;
    logic        jmp;
    logic [5:0]  jmp_target;
    logic        ir_valid;
    logic [31:0] ir_data;
    logic [5:0]  ir_pc;
    logic        ir_ready;

    int n_vec = 0;
    int n_err = 0;

    ib32bit_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .next_pc    (next_pc),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp        (jmp),
        .jmp_target (jmp_target),
        .ir_valid   (ir_valid),
        .ir_data    (ir_data),
        .ir_pc      (ir_pc),
        .ir_ready   (ir_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        pc         <= next_pc;
        imem_rdata <= 32'hA000_0000 + {26'd0, imem_addr};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ir_ready = 1'b1; br_taken = 1'b0; jmp = 1'b0;
        br_target = '0; jmp_target = '0;
        tick(); tick();
        @(negedge clk);
        n_vec++;
        if (ir_valid !== 1'b0) begin n_err++; $display("FAIL reset_ir_valid: got %0d want 0", ir_valid); end
        n_vec++;
        if (ir_data !== 32'd0) begin n_err++; $display("FAIL reset_ir_data: got %0h want 0", ir_data); end
        n_vec++;
        if (ir_pc !== 6'd0) begin n_err++; $display("FAIL reset_ir_pc: got %0d want 0", ir_pc); end
        n_vec++;
        if (next_pc !== 6'd0) begin n_err++; $display("FAIL reset_next_pc: got %0d want 0", next_pc); end
    endtask

    task automatic test_stream();
        tick(); rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (ir_valid !== 1'b0 || next_pc !== 6'd1 || imem_addr !== 6'd0) begin
            n_err++;
            $display("FAIL stream_c0: got valid=%0d next_pc=%0d addr=%0d want 0/1/0", ir_valid, next_pc, imem_addr);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if (ir_valid !== 1'b0) begin n_err++; $display("FAIL stream_c1_valid: got %0d want 0", ir_valid); end
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            n_vec++;
            if (ir_valid !== 1'b1 || ir_pc !== 6'(k) || ir_data !== 32'hA000_0000 + 32'(k)) begin
                n_err++;
                $display("FAIL stream_pc%0d: got valid=%0d pc=%0d data=%0h want 1/%0d/%0h",
                         k, ir_valid, ir_pc, ir_data, k, 32'hA000_0000 + 32'(k));
            end
        end
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 4; c++) begin
            tick(); ir_ready = 1'b0;
            @(negedge clk);
            n_vec++;
            if (ir_valid !== 1'b1 || ir_pc !== 6'd5 || ir_data !== 32'hA000_0005 || next_pc !== 6'd7) begin
                n_err++;
                $display("FAIL stall_hold%0d: got valid=%0d pc=%0d data=%0h next_pc=%0d want 1/5/a0000005/7",
                         c, ir_valid, ir_pc, ir_data, next_pc);
            end
        end
        for (int k = 5; k < 8; k++) begin
            tick(); ir_ready = 1'b1;
            @(negedge clk);
            n_vec++;
            if (ir_valid !== 1'b1 || ir_pc !== 6'(k) || ir_data !== 32'hA000_0000 + 32'(k)) begin
                n_err++;
                $display("FAIL stall_drain%0d: got valid=%0d pc=%0d data=%0h want 1/%0d",
                         k, ir_valid, ir_pc, ir_data, k);
            end
        end
    endtask

    task automatic test_branch();
        // PC 9 is in flight and PC 10 is at the PC register in this cycle.
        tick(); br_taken = 1'b1; br_target = 6'd20;
        @(negedge clk);
        n_vec++;
        if (next_pc !== 6'd20 || ir_pc !== 6'd8) begin
            n_err++;
            $display("FAIL br_next_pc: got next_pc=%0d ir_pc=%0d want 20/8", next_pc, ir_pc);
        end
        for (int b = 0; b < 2; b++) begin
            tick(); br_taken = 1'b0;
            @(negedge clk);
            n_vec++;
            if (ir_valid !== 1'b0) begin
                n_err++;
                $display("FAIL br_bubble%0d: got valid=%0d pc=%0d want valid 0", b, ir_valid, ir_pc);
            end
        end
        for (int k = 20; k < 23; k++) begin
            tick();
            @(negedge clk);
            n_vec++;
            if (ir_valid !== 1'b1 || ir_pc !== 6'(k) || ir_data !== 32'hA000_0000 + 32'(k)) begin
                n_err++;
                $display("FAIL br_target%0d: got valid=%0d pc=%0d data=%0h want 1/%0d",
                         k, ir_valid, ir_pc, ir_data, k);
            end
        end
    endtask

    task automatic test_simultaneous();
        tick(); br_taken = 1'b1; br_target = 6'd30; jmp = 1'b1; jmp_target = 6'd12;
        @(negedge clk);
        n_vec++;
        if (next_pc !== 6'd30) begin n_err++; $display("FAIL both_next_pc: got %0d want 30", next_pc); end
        tick(); br_taken = 1'b0; jmp = 1'b0;
        tick();
        for (int k = 30; k < 32; k++) begin
            tick();
            @(negedge clk);
            n_vec++;
            if (ir_valid !== 1'b1 || ir_pc !== 6'(k)) begin
                n_err++;
                $display("FAIL both_seq%0d: got valid=%0d pc=%0d want 1/%0d", k, ir_valid, ir_pc, k);
            end
        end
    endtask

    task automatic test_wrap();
        tick(); jmp = 1'b1; jmp_target = 6'd62;
        @(negedge clk);
        n_vec++;
        if (next_pc !== 6'd62) begin n_err++; $display("FAIL jmp_next_pc: got %0d want 62", next_pc); end
        tick(); jmp = 1'b0;
        @(negedge clk);
        n_vec++;
        if (next_pc !== 6'd63) begin n_err++; $display("FAIL wrap_62: got next_pc=%0d want 63", next_pc); end
        tick();
        @(negedge clk);
        n_vec++;
        if (next_pc !== 6'd0) begin n_err++; $display("FAIL wrap_63: got next_pc=%0d want 0", next_pc); end
        for (int k = 0; k < 4; k++) begin
            automatic logic [5:0] want = 6'(62 + k);
            tick();
            @(negedge clk);
            n_vec++;
            if (ir_valid !== 1'b1 || ir_pc !== want || ir_data !== 32'hA000_0000 + {26'd0, want}) begin
                n_err++;
                $display("FAIL wrap_seq%0d: got valid=%0d pc=%0d data=%0h want 1/%0d", k, ir_valid, ir_pc, ir_data, want);
            end
        end
    endtask

    task automatic test_midreset();
        tick(); ir_ready = 1'b0;
        tick();
        @(negedge clk);
        n_vec++;
        if (ir_valid !== 1'b1 || ir_pc !== 6'd2) begin
            n_err++;
            $display("FAIL mr_stall: got valid=%0d pc=%0d want 1/2", ir_valid, ir_pc);
        end
        tick(); rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (next_pc !== 6'd0) begin n_err++; $display("FAIL mr_next_pc: got %0d want 0", next_pc); end
        tick(); rst = 1'b0; ir_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (ir_valid !== 1'b0 || ir_pc !== 6'd0 || ir_data !== 32'd0) begin
            n_err++;
            $display("FAIL mr_cleared: got valid=%0d pc=%0d data=%0h want 0/0/0", ir_valid, ir_pc, ir_data);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if (ir_valid !== 1'b0) begin n_err++; $display("FAIL mr_bubble: got valid=%0d want 0", ir_valid); end
        tick();
        @(negedge clk);
        n_vec++;
        if (ir_valid !== 1'b1 || ir_pc !== 6'd0 || ir_data !== 32'hA000_0000) begin
            n_err++;
            $display("FAIL mr_first: got valid=%0d pc=%0d data=%0h want 1/0/a0000000", ir_valid, ir_pc, ir_data);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_branch();
        test_simultaneous();
        test_wrap();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
